// File: rtl/fifo_width_downsizer_pkg.sv
// Shared widths for the width-expanding / width-downsizing FIFO pair.
// Keeping the defaults here holds both sides of the round trip matched.
package fifo_width_downsizer_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_WIDTH      = 32;

  typedef enum logic {
    HALF_UPPER = 1'b0,
    HALF_LOWER = 1'b1
  } half_sel_e;

endpackage

// File: rtl/fifo_word_mem.sv
// Word storage: synchronous write port, asynchronous read port.
// Contents are deliberately left unreset.
module fifo_word_mem #(
  parameter int ADDR_WIDTH = 3,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH_P2 = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH_P2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_width_downsizer.sv
// FIFO taking WIDTH-bit words and delivering WIDTH/2-bit halves,
// upper half first, with first-word-fall-through output.
module fifo_width_downsizer
  import fifo_width_downsizer_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DEPTH_P2   = 1 << ADDR_WIDTH,
  parameter int WIDTH      = FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  put,
  input  logic                  get,
  output logic [WIDTH/2-1:0]    data_out,
  output logic [ADDR_WIDTH+1:0] fillcount,
  output logic                  empty,
  output logic                  full
);

  localparam int HW = WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = DEPTH_P2[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  half_sel_e             half_sel_q, half_sel_d;

  logic             put_ok;
  logic             get_ok;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign empty  = (words_q == '0);
  assign full   = (words_q == CNT_FULL);
  assign put_ok = put && !full;
  assign get_ok = get && !empty;
  // A slot is released only when its lower half leaves.
  assign pop    = get_ok && (half_sel_q == HALF_LOWER);

  fifo_word_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (put_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    words_d    = words_q;
    half_sel_d = half_sel_q;
    if (put_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (get_ok) begin
      half_sel_d = (half_sel_q == HALF_UPPER) ? HALF_LOWER : HALF_UPPER;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({put_ok, pop})
      2'b10:   words_d = words_q + CNT_ONE;
      2'b01:   words_d = words_q - CNT_ONE;
      default: words_d = words_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      words_q    <= '0;
      half_sel_q <= HALF_UPPER;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      words_q    <= words_d;
      half_sel_q <= half_sel_d;
    end
  end

  assign fillcount = {words_q, 1'b0}
                   - {{(ADDR_WIDTH+1){1'b0}}, half_sel_q};

  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = (half_sel_q == HALF_LOWER) ? head[HW-1:0]
                                            : head[WIDTH-1:HW];
    end
  end

endmodule

// File: tb/tb_fifo_width_downsizer.sv
// Bench for fifo_width_downsizer: vector table, half-word scoreboard,
// hand sequences for wrap / full corner cases and a random phase.
module tb_fifo_width_downsizer;

  localparam int AW    = 3;
  localparam int W     = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          put = 1'b0;
  logic          get = 1'b0;
  logic [W/2-1:0] data_out;
  logic [AW+1:0] fillcount;
  logic          empty;
  logic          full;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] sb [$];

  fifo_width_downsizer #(
    .ADDR_WIDTH (AW),
    .DEPTH_P2   (DEPTH),
    .WIDTH      (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .put       (put),
    .get       (get),
    .data_out  (data_out),
    .fillcount (fillcount),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        put;
    logic        get;
    logic [31:0] din;
    int          fill;
    logic        emp;
    logic        ful;
    logic [15:0] dout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    int sz;
    sz = sb.size();
    chk("fillcount", 32'(fillcount), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(((sz + 1) / 2) == DEPTH));
    chk("data_out", 32'(data_out), (sz != 0) ? 32'(sb[0]) : 32'h0);
  endtask

  // One clock: predict acceptance from pre-edge model, then compare.
  task automatic cycle(input logic r, input logic p, input logic g,
                       input logic [31:0] d);
    bit acc_p;
    bit acc_g;
    reset   = r;
    put     = p;
    get     = g;
    data_in = d;
    acc_p = r && p && (((sb.size() + 1) / 2) < DEPTH);
    acc_g = r && g && (sb.size() != 0);
    if (acc_g) chk("sb_head", 32'(data_out), 32'(sb[0]));
    @(posedge clk);
    #1;
    if (!r) begin
      sb.delete();
    end else begin
      if (acc_g) void'(sb.pop_front());
      if (acc_p) begin
        sb.push_back(d[31:16]);
        sb.push_back(d[15:0]);
      end
    end
    put = 1'b0;
    get = 1'b0;
    reset = 1'b1;
    chk_model();
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        0, 1'b1, 1'b0, 16'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,        0, 1'b1, 1'b0, 16'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b1, 1'b0, 16'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0,        0, 1'b1, 1'b0, 16'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'hAAAA5555, 2, 1'b0, 1'b0, 16'hAAAA};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0,        1, 1'b0, 1'b0, 16'h5555};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0,        0, 1'b1, 1'b0, 16'h0};

    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].rst_n, vecs[i].put, vecs[i].get, vecs[i].din);
      chk($sformatf("vec%0d_fill", i), 32'(fillcount), 32'(vecs[i].fill));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
      chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].dout));
    end

    // Fill, overflow attempt, drain; twice to cross pointer wrap.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < DEPTH; i++)
        cycle(1'b1, 1'b1, 1'b0, {16'(2*i+1), 16'(2*i+2)});
      chk("fill_full", 32'(full), 32'h1);
      chk("fill_count", 32'(fillcount), 32'd16);
      cycle(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
      chk("ovf_count", 32'(fillcount), 32'd16);
      for (int i = 0; i < 2 * DEPTH; i++) begin
        chk("drain_seq", 32'(data_out), 32'(i + 1));
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
      end
      chk("drain_empty", 32'(empty), 32'h1);
    end

    // Full persists while the head word is only half consumed.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(i));
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    chk("half_full", 32'(full), 32'h1);
    chk("half_fill", 32'(fillcount), 32'd15);
    cycle(1'b1, 1'b1, 1'b0, 32'hBAD0BAD0);
    chk("half_put_ign", 32'(fillcount), 32'd15);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    chk("half_full2", 32'(full), 32'h0);
    chk("half_fill2", 32'(fillcount), 32'd14);
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b1, 32'h0);

    // Simultaneous put/get on both half positions.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 1'b0, 32'h2000_0000 + 32'(i));
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    chk("sim_pre", 32'(fillcount), 32'd5);
    cycle(1'b1, 1'b1, 1'b1, 32'h3333_4444);
    chk("sim_pop", 32'(fillcount), 32'd6);
    cycle(1'b1, 1'b1, 1'b1, 32'h5555_6666);
    chk("sim_half", 32'(fillcount), 32'd7);

    // Reset mid-stream with 5 words and half_sel=1.
    cycle(1'b1, 1'b1, 1'b0, 32'h7777_8888);
    chk("rst_pre", 32'(fillcount), 32'd9);
    cycle(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_fill", 32'(fillcount), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    chk("rst_hi", 32'(data_out), 32'h1234);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    chk("rst_lo", 32'(data_out), 32'h5678);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom),
            $urandom);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
